// File: rtl/log_perf_pkg.sv
// Shared types and constants for the log/perf control block.
package log_perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMP  = 2'd1,
    CLEAN = 2'd2
  } state_e;

  // Bit positions inside a 2-bit request/trigger kind.
  localparam int unsigned KIND_DUMP  = 1;
  localparam int unsigned KIND_CLEAN = 0;

  localparam int unsigned DEF_TIMER_W  = 64;
  localparam int unsigned DEF_PERIOD_W = 32;
  localparam int unsigned DEF_CNT_W    = 32;

endpackage

// File: rtl/log_perf_ctrl_if.sv
// Configuration, request handshake and log/perf output bundle.
// master: simulation-top driver side; slave: log_perf_ctrl side.
interface log_perf_ctrl_if
  import log_perf_pkg::*;
#(
  parameter int unsigned TIMER_W  = DEF_TIMER_W,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
);

  logic                cfg_valid;
  logic [TIMER_W-1:0]  cfg_log_begin;
  logic [TIMER_W-1:0]  cfg_log_end;
  logic [PERIOD_W-1:0] cfg_dump_period;

  logic                req_valid;
  logic [1:0]          req_kind;
  logic                req_ready;

  logic [TIMER_W-1:0]  timer;
  logic                logEnable;
  logic                dump;
  logic                clean;
  logic [CNT_W-1:0]    dump_count;

  modport master (
    output cfg_valid, cfg_log_begin, cfg_log_end, cfg_dump_period,
    output req_valid, req_kind,
    input  req_ready, timer, logEnable, dump, clean, dump_count
  );

  modport slave (
    input  cfg_valid, cfg_log_begin, cfg_log_end, cfg_dump_period,
    input  req_valid, req_kind,
    output req_ready, timer, logEnable, dump, clean, dump_count
  );

endinterface

// File: rtl/log_perf_period_timer.sv
// Periodic dump trigger: period counter, optional window gating, and a
// single-entry pending flag for triggers that arrive while a sequence runs.
// Build option: LOGPERF_WINDOW_GATE_EN discards periodic triggers raised
// while logEnable is low.
module log_perf_period_timer
  import log_perf_pkg::*;
#(
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  input  logic                log_enable,
  input  logic                idle,
  output logic                fire,
  output logic                pending
);

  logic [PERIOD_W-1:0] cnt_q;
  logic                pending_q;
  logic                trig;
  logic                trig_eff;

  assign trig = (period != '0) && (cnt_q == period - PERIOD_W'(1));

`ifdef LOGPERF_WINDOW_GATE_EN
  assign trig_eff = trig && log_enable;
`else
  logic unused_log_enable;
  assign unused_log_enable = log_enable;
  assign trig_eff          = trig;
`endif

  // Counter runs 0..period-1 in every FSM state; a config load restarts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (period != '0) begin
      cnt_q <= trig ? '0 : cnt_q + PERIOD_W'(1);
    end
  end

  // Pending is consumed by any IDLE cycle (the FSM starts the sequence there);
  // outside IDLE it latches one trigger and drops any further ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= !idle && (pending_q || trig_eff);
    end
  end

  assign fire    = trig_eff || pending_q;
  assign pending = pending_q;

endmodule

// File: rtl/log_perf_ctrl.sv
// Simulation-top source of the log/perf control bundle: free-running cycle
// timer, [begin,end) log window, and dump->clean pulse sequencing on periodic
// triggers or manual requests.
// Build option: LOGPERF_WINDOW_GATE_EN (see log_perf_period_timer).
module log_perf_ctrl
  import log_perf_pkg::*;
#(
  parameter int unsigned          TIMER_W     = DEF_TIMER_W,
  parameter int unsigned          PERIOD_W    = DEF_PERIOD_W,
  parameter int unsigned          CNT_W       = DEF_CNT_W,
  parameter logic [TIMER_W-1:0]   LOG_BEGIN   = '0,
  parameter logic [TIMER_W-1:0]   LOG_END     = '0,
  parameter logic [PERIOD_W-1:0]  DUMP_PERIOD = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  log_perf_ctrl_if.slave bus
);

  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [TIMER_W-1:0]  begin_q, begin_d;
  logic [TIMER_W-1:0]  end_q, end_d;
  logic [PERIOD_W-1:0] period_q;
  logic                log_q;

  state_e              state_q, state_d;
  logic                chain_clean_q, chain_clean_d;
  logic                dump_q, clean_q;
  logic [CNT_W-1:0]    count_q;

  logic                idle;
  logic                fire;
  logic                pending;
  logic                accept;
  logic [1:0]          start_kind;

  assign timer_d = timer_q + TIMER_W'(1);
  assign begin_d = bus.cfg_valid ? bus.cfg_log_begin : begin_q;
  assign end_d   = bus.cfg_valid ? bus.cfg_log_end   : end_q;

  // Timer, config registers and window flag. The window is evaluated on the
  // next timer value and the post-load bounds so that logEnable always matches
  // the timer and bounds visible in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= '0;
      log_q    <= 1'b0;
      begin_q  <= LOG_BEGIN;
      end_q    <= LOG_END;
      period_q <= DUMP_PERIOD;
    end else begin
      timer_q <= timer_d;
      log_q   <= (begin_d <= timer_d) && (timer_d < end_d);
      begin_q <= begin_d;
      end_q   <= end_d;
      if (bus.cfg_valid) begin
        period_q <= bus.cfg_dump_period;
      end
    end
  end

  assign idle = (state_q == IDLE);

  log_perf_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_period (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (bus.cfg_valid),
    .period     (period_q),
    .log_enable (log_q),
    .idle       (idle),
    .fire       (fire),
    .pending    (pending)
  );

  assign bus.req_ready = idle && !pending;

  // Next state: in IDLE a periodic fire (dump+clean) and an accepted request
  // are OR-merged into one sequence; DUMP chains to CLEAN only if asked.
  always_comb begin
    state_d       = state_q;
    chain_clean_d = chain_clean_q;
    accept        = 1'b0;
    start_kind    = '0;
    unique case (state_q)
      IDLE: begin
        accept        = bus.req_valid && bus.req_ready;
        start_kind    = (fire ? 2'b11 : 2'b00) | (accept ? bus.req_kind : 2'b00);
        chain_clean_d = start_kind[KIND_CLEAN];
        if (start_kind[KIND_DUMP]) begin
          state_d = DUMP;
        end else if (start_kind[KIND_CLEAN]) begin
          state_d = CLEAN;
        end
      end
      DUMP:    state_d = chain_clean_q ? CLEAN : IDLE;
      CLEAN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered pulses and saturating dump counter; the
  // counter advances on the same edge the dump pulse rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      chain_clean_q <= 1'b0;
      dump_q        <= 1'b0;
      clean_q       <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      chain_clean_q <= chain_clean_d;
      dump_q        <= (state_d == DUMP);
      clean_q       <= (state_d == CLEAN);
      if ((state_d == DUMP) && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.timer      = timer_q;
  assign bus.logEnable  = log_q;
  assign bus.dump       = dump_q;
  assign bus.clean      = clean_q;
  assign bus.dump_count = count_q;

endmodule

// File: tb/tb_log_perf_ctrl.sv
// Scoreboard bench for log_perf_ctrl. Narrow timer (wraps quickly) and narrow
// dump counter (saturates quickly). Honours LOGPERF_WINDOW_GATE_EN.
module tb_log_perf_ctrl;

  localparam int unsigned TW   = 8;
  localparam int unsigned PW   = 8;
  localparam int unsigned CW   = 4;
  localparam int          TMOD = 1 << TW;
  localparam int          CMAX = (1 << CW) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  log_perf_ctrl_if #(.TIMER_W(TW), .PERIOD_W(PW), .CNT_W(CW)) bus ();

  log_perf_ctrl #(.TIMER_W(TW), .PERIOD_W(PW), .CNT_W(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int cyc;
    bit is_dump;
    int count;
  } pulse_t;

  pulse_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model state
  int t;
  int beg, fin, per, base;
  bit pend;
  int last_sched;
  int mcount;
  int exp_timer;
  bit exp_log, exp_ready;
  bit in_reset = 1'b1;
  bit checking = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: t=%0d got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    beg = 0; fin = 0; per = 0; base = 0;
    pend = 1'b0; last_sched = -1; mcount = 0; t = 0;
    exp_q.delete();
  endtask

  // One cycle of the reference: pulses are scheduled as absolute cycle numbers;
  // the controller counts as idle once every scheduled pulse lies in the past.
  task automatic model_step();
    int tmr;
    bit log_en, trig, idle;
    int kind;
    tmr    = t % TMOD;
    log_en = (beg <= tmr) && (tmr < fin);
    trig   = (per != 0) && (((t - base) % per) == per - 1);
    idle   = (last_sched < t);
    kind   = 0;
    exp_timer = tmr;
    exp_log   = log_en;
    exp_ready = idle && !pend;
`ifdef LOGPERF_WINDOW_GATE_EN
    if (!log_en) trig = 1'b0;
`endif
    if (idle) begin
      if (trig || pend) kind = 3;
      if (bus.req_valid && exp_ready) kind = kind | int'(bus.req_kind);
      pend = 1'b0;
      if ((kind & 2) != 0) begin
        if (mcount < CMAX) mcount++;
        exp_q.push_back('{t + 1, 1'b1, mcount});
        last_sched = t + 1;
      end
      if ((kind & 1) != 0) begin
        last_sched = ((kind & 2) != 0) ? t + 2 : t + 1;
        exp_q.push_back('{last_sched, 1'b0, mcount});
      end
    end else if (trig) begin
      pend = 1'b1;
    end
    if (bus.cfg_valid) begin
      beg  = int'(bus.cfg_log_begin);
      fin  = int'(bus.cfg_log_end);
      per  = int'(bus.cfg_dump_period);
      base = t + 1;
    end
  endtask

  task automatic drive(input bit cv, input int b, input int e, input int p,
                       input bit rv, input int rk);
    bus.cfg_valid       = cv;
    bus.cfg_log_begin   = TW'(b);
    bus.cfg_log_end     = TW'(e);
    bus.cfg_dump_period = PW'(p);
    bus.req_valid       = rv;
    bus.req_kind        = 2'(rk);
    model_step();
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 0);
  endtask

  // Monitor: checks per-cycle outputs and pops the scoreboard on each pulse.
  always @(negedge clock) begin
    if (checking) begin
      if (in_reset) begin
        chk("rst_timer", int'(bus.timer), 0);
        chk("rst_log", int'(bus.logEnable), 0);
        chk("rst_dump", int'(bus.dump), 0);
        chk("rst_clean", int'(bus.clean), 0);
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_count", int'(bus.dump_count), 0);
      end else begin
        chk("timer", int'(bus.timer), exp_timer);
        chk("logEnable", int'(bus.logEnable), int'(exp_log));
        chk("req_ready", int'(bus.req_ready), int'(exp_ready));
        if (bus.dump && bus.clean) chk("dump_clean_overlap", 1, 0);
        if (bus.dump || bus.clean) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'(bus.dump) * 2 + int'(bus.clean), 0);
          end else begin
            pulse_t e;
            e = exp_q.pop_front();
            chk("pulse_cycle", t, e.cyc);
            chk("pulse_is_dump", int'(bus.dump), int'(e.is_dump));
            chk("dump_count", int'(bus.dump_count), e.count);
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= t) begin
          pulse_t e;
          e = exp_q.pop_front();
          chk("missed_pulse_cycle", -1, e.cyc);
        end
      end
    end
  end

  initial begin
    bit found;
    bus.cfg_valid = 1'b0; bus.cfg_log_begin = '0; bus.cfg_log_end = '0;
    bus.cfg_dump_period = '0; bus.req_valid = 1'b0; bus.req_kind = '0;
    model_reset();
    #1;
    checking = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset_n  = 1'b1;
    in_reset = 1'b0;
    model_reset();

    // Window [10,20)
    drive(1'b1, 10, 20, 0, 1'b0, 0);
    idle_cycles(30);
    // Degenerate window
    drive(1'b1, 5, 5, 0, 1'b0, 0);
    idle_cycles(20);
    // Periodic dump every 8 cycles, window open
    drive(1'b1, 0, 255, 8, 1'b0, 0);
    idle_cycles(40);
    // Manual requests of each kind
    drive(1'b1, 0, 0, 0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 0, 0, 0, 1'b1, (k + 1) % 4);
      idle_cycles(4);
    end
    // Periodic triggers colliding with a held clean request
    drive(1'b1, 0, 255, 5, 1'b0, 0);
    for (int i = 0; i < 40; i++) drive(1'b0, 0, 0, 0, 1'b1, 1);
    // Closed window with short period
    drive(1'b1, 0, 0, 4, 1'b0, 0);
    idle_cycles(20);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 49) == 0, int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 9)),
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a dump pulse
    drive(1'b1, 0, 255, 3, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == t && exp_q[0].is_dump) found = 1'b1;
      else drive(1'b0, 0, 0, 0, 1'b0, 0);
    end
    if (!found) begin
      chk("dump_wait_timeout", 0, 1);
    end else begin
      #1;
      chk("dump_before_reset", int'(bus.dump), 1);
      reset_n  = 1'b0;
      in_reset = 1'b1;
      #1;
      chk("abort_dump", int'(bus.dump), 0);
      chk("abort_clean", int'(bus.clean), 0);
    end
    reset_n  = 1'b0;
    in_reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset_n  = 1'b1;
    in_reset = 1'b0;
    model_reset();
    for (int i = 0; i < 30; i++) drive(1'b0, 0, 0, 0, $urandom_range(0, 3) == 0,
                                       int'($urandom_range(0, 3)));
    idle_cycles(4);
    chk("scoreboard_empty", exp_q.size(), 0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
